mc_ctrl_gen: RTL and testbench
==============================

MC_CTRL_GEN -- requirements
Module: mc_ctrl_gen

Interface
REQ-001 SHALL have parameter ALUC_W, default 4, ALUControl width (min 4); codes occupy the low 4 bits, upper bits 0.
REQ-002 SHALL have parameter WAIT_MAX, default 15, memory stall cycles tolerated before timeout (1..255).
REQ-003 SHALL have ports: clk in 1, the single clock; RESET_N in 1, synchronous active-low reset.
REQ-004 SHALL have inputs: Cond 4 (instr[31:28]); Op 2; Funct 6; Rd 4; ALUFlags 4 (N,Z,C,V = [3:0]); MemReady 1 (memory access completes this cycle).
REQ-005 SHALL have outputs: PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, BL_ctrl, Busy, Timeout (1 each); ResultSrc 2; ALUSrcB 2; ImmSrc 2; RegSrc 2; ALUControl ALUC_W.

Function
REQ-006 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, LINK, ERROR in a 4-bit state register.
REQ-007 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; while MemReady=0, hold with IRWrite=0 and PCWrite=0; on MemReady=1, IRWrite=1, PCWrite=1, go DECODE.
REQ-008 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; latch CondEx; Op=00 -> EXECI if Funct[5] else EXECR; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH.
REQ-009 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD; Funct[0]=1 -> MEMREAD, else MEMWRITE.
REQ-010 MEMREAD: AdrSrc=1; stay until MemReady=1, then MEMWB. MEMWB: ResultSrc=01, RegW=1, go FETCH.
REQ-011 MEMWRITE: AdrSrc=1, MemW=1 held every stall cycle; on MemReady=1 go FETCH.
REQ-012 EXECR (ALUSrcB=00) / EXECI (ALUSrcB=01): ALUOp=1, go ALUWB; ALUWB: ResultSrc=00, RegW=1 unless Funct[4:1]=1010 (CMP), go FETCH.
REQ-013 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1; Funct[4]=1 and BL enabled -> LINK, else FETCH.
REQ-014 ALU decode when ALUOp=1 on Funct[4:1]: 0100 ADD=0100, 0010 SUB=0010, 1010 CMP=0010, 0000 AND=0000, 1100 ORR=1100, 1101 MOV=1101; other -> SUB; ALUOp=0 -> ADD (0100).
REQ-015 FlagW: Funct[0]=0 -> 00; ADD/SUB/CMP -> 11; AND/ORR/MOV -> 10; CMP always 11; flags written only in EXECR/EXECI, gated by latched CondEx.
REQ-016 Condition check SHALL cover all ARM codes 0000..1110 (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL) on registered flags; 1111 -> 0.
REQ-017 RegWrite=RegW&CondEx; MemWrite=MemW&CondEx; PCWrite=FETCH-advance | (PCS&CondEx), PCS=Branch | (RegW & Rd=1111).
REQ-018 ImmSrc=Op; RegSrc[0]=(Op=10); RegSrc[1]=(Op=01); all combinational.
REQ-019 Stall counter: increments each FETCH/MEMREAD/MEMWRITE cycle with MemReady=0; clears on any state change; at count=WAIT_MAX with MemReady=0 -> ERROR; MemReady=1 on that same cycle wins (normal advance).
REQ-020 ERROR: sticky until reset; Timeout=1; all write enables 0.
REQ-021 Busy=1 in every state except FETCH and ERROR.

Reset
REQ-022 RESET_N=0 at a clk edge SHALL force state FETCH, flags 0000, CondEx 0, stall counter 0, from any state including mid-stall and ERROR.
REQ-023 During/after reset: Timeout=0, Busy=0, BL_ctrl=0, MemWrite=0, RegWrite=0; FETCH outputs per REQ-007.

Configuration
REQ-024 Macro MC_CTRL_BL_EN SHALL compile in LINK: RegW=1, BL_ctrl=1, ResultSrc=10 (PC to R14), then FETCH.
REQ-025 Without MC_CTRL_BL_EN: no LINK state, BL_ctrl tied 0, BL executes as plain B.

Verification
REQ-026 ADD R1 (Cond=1110, Op=00, Funct=001000), MemReady=1 -> FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB; 4 cycles.
REQ-027 LDR (Op=01, Funct[0]=1), MemReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, MEMWB RegWrite=1.
REQ-028 SUBS sets Z=1 then BNE (Cond=0001) -> PCWrite=0 in BRANCH; BEQ -> PCWrite=1.
REQ-029 MemReady held 0 in FETCH, WAIT_MAX=15 -> ERROR after 16 stall cycles, Timeout=1; RESET_N=0 one cycle -> FETCH, Timeout=0.
REQ-030 BL (Op=10, Funct[4]=1) with MC_CTRL_BL_EN -> BRANCH then LINK, BL_ctrl=1, RegWrite=1; without it, BRANCH then FETCH.
REQ-031 CMP with Cond=1100 (GT), flags N=V=1,Z=0 -> flags update; with Z=1 -> no flag update, RegWrite=0.

Source files
------------

// File: rtl/mc_ctrl_gen.sv
// -----------------------------------------------------------------------------
// mc_ctrl_gen -- multicycle control unit for an ARM-subset datapath.
//
// The state machine steps each instruction through fetch, decode and the
// execute/memory/writeback states. It decodes the ALU operation and the flag
// write mask, holds the NZCV flags, and evaluates the ARM condition field.
// A stall counter bounds how long a memory access may stay not-ready. When
// the bound is exceeded, the unit parks in ERROR until reset.
//
// Parameters
//   ALUC_W    ALUControl width (>= 4). The code occupies the low 4 bits.
//   WAIT_MAX  Stall cycles tolerated per memory access (1..255).
//
// Ports
//   clk, RESET_N              clock and synchronous active-low reset
//   Cond, Op, Funct, Rd       instruction fields, held stable for the instruction
//   ALUFlags                  ALU result flags {N,Z,C,V}
//   MemReady                  the memory access completes this cycle
//   PCWrite .. Timeout        datapath write enables and status flags
//   ResultSrc, ALUSrcB        datapath mux selects
//   ImmSrc, RegSrc            combinational decodes of Op
//   ALUControl                ALU operation code
//
// Build option
//   MC_CTRL_BL_EN  Adds the LINK state, so that BL writes PC to R14.
//                  Without it, BL executes as a plain B.
// -----------------------------------------------------------------------------
module mc_ctrl_gen #(
  parameter int ALUC_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic [3:0]        Cond,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic [3:0]        ALUFlags,
  input  logic              MemReady,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              ALUSrcA,
  output logic              RegWrite,
  output logic              BL_ctrl,
  output logic              Busy,
  output logic              Timeout,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
`ifdef MC_CTRL_BL_EN
    LINK     = 4'd10,
`endif
    ERROR    = 4'd11
  } state_t;

  state_t     state, next_state;
  logic [3:0] flags;        // {N,Z,C,V}
  logic       cond_ex;
  logic [7:0] stall_cnt;

  logic       cond_pass, waiting, timeout_hit, is_cmp, is_logic;
  logic       alu_op, reg_w, mem_w, branch, fetch_adv, pcs;
  logic [1:0] flag_w;
  logic [3:0] alu_code;

  // Condition check against the registered flags.
  always_comb begin
    case (Cond)
      4'b0000: cond_pass = flags[2];
      4'b0001: cond_pass = ~flags[2];
      4'b0010: cond_pass = flags[1];
      4'b0011: cond_pass = ~flags[1];
      4'b0100: cond_pass = flags[3];
      4'b0101: cond_pass = ~flags[3];
      4'b0110: cond_pass = flags[0];
      4'b0111: cond_pass = ~flags[0];
      4'b1000: cond_pass = flags[1] & ~flags[2];
      4'b1001: cond_pass = ~flags[1] | flags[2];
      4'b1010: cond_pass = (flags[3] == flags[0]);
      4'b1011: cond_pass = (flags[3] != flags[0]);
      4'b1100: cond_pass = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_pass = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // A memory wait cycle counts as a stall. The last tolerated stall escalates
  // to ERROR. A ready on that same cycle takes the normal path instead.
  assign waiting     = ((state == FETCH) || (state == MEMREAD) || (state == MEMWRITE))
                       && !MemReady;
  assign timeout_hit = waiting && (stall_cnt == 8'(WAIT_MAX));

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (MemReady) next_state = DECODE;
      DECODE:
        case (Op)
          2'b00:   next_state = Funct[5] ? EXECI : EXECR;
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      MEMADR:   next_state = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  if (MemReady) next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: if (MemReady) next_state = FETCH;
      EXECR,
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
`ifdef MC_CTRL_BL_EN
      BRANCH:   next_state = Funct[4] ? LINK : FETCH;
      LINK:     next_state = FETCH;
`else
      BRANCH:   next_state = FETCH;
`endif
      ERROR:    next_state = ERROR;
      default:  next_state = FETCH;
    endcase
    if (timeout_hit) next_state = ERROR;
  end

  // ALU decode. CMP (1010) shares the SUB code and always writes all four
  // flags. Opcodes that are not listed fall back to SUB with arithmetic flags.
  assign is_cmp   = (Funct[4:1] == 4'b1010);
  assign is_logic = (Funct[4:1] == 4'b0000) || (Funct[4:1] == 4'b1100) ||
                    (Funct[4:1] == 4'b1101);

  always_comb begin
    alu_code = 4'b0100;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: alu_code = 4'b0100;
        4'b0000: alu_code = 4'b0000;
        4'b1100: alu_code = 4'b1100;
        4'b1101: alu_code = 4'b1101;
        default: alu_code = 4'b0010;
      endcase
    end
  end

  assign flag_w = is_cmp    ? 2'b11 :
                  !Funct[0] ? 2'b00 :
                  is_logic  ? 2'b10 : 2'b11;

  // Per-state control decode.
  // NOTE: every signal gets a default before the case statement, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    IRWrite   = 1'b0;
    fetch_adv = 1'b0;
    alu_op    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    BL_ctrl   = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        fetch_adv = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECR:    alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB:    reg_w = !is_cmp;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
`ifdef MC_CTRL_BL_EN
      LINK: begin
        ResultSrc = 2'b10;
        reg_w     = 1'b1;
        BL_ctrl   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Writing R15 from a register-writing state counts as a PC write.
  assign pcs        = branch | (reg_w & (Rd == 4'b1111));
  assign PCWrite    = fetch_adv | (pcs & cond_ex);
  assign RegWrite   = reg_w & cond_ex;
  assign MemWrite   = mem_w & cond_ex;
  assign Busy       = (state != FETCH) && (state != ERROR);
  assign Timeout    = (state == ERROR);
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign ALUControl = ALUC_W'(alu_code);

  // NOTE: state registers use non-blocking assignments. Every register then
  // samples the values from before the edge, whatever order the code runs in.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state     <= FETCH;
      flags     <= 4'b0000;
      cond_ex   <= 1'b0;
      stall_cnt <= 8'd0;
    end else begin
      state <= next_state;
      if (next_state != state) stall_cnt <= 8'd0;
      else if (waiting)        stall_cnt <= stall_cnt + 8'd1;
      if (state == DECODE) cond_ex <= cond_pass;
      // A failed condition suppresses the flag update as well as the writes.
      if (((state == EXECR) || (state == EXECI)) && cond_ex) begin
        if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

endmodule

// File: tb/tb_mc_ctrl_gen.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_gen -- directed bench for mc_ctrl_gen.
//
// The bench drives instruction sequences one cycle at a time. At each
// negedge it compares the packed output vector against hand-derived
// per-state constants.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_gen;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, BL_ctrl, Busy, Timeout;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [5:0] ALUControl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl_gen #(.ALUC_W(6), .WAIT_MAX(15)) dut (
    .clk(clk), .RESET_N(RESET_N), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .BL_ctrl(BL_ctrl), .Busy(Busy), .Timeout(Timeout), .ResultSrc(ResultSrc),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  logic [18:0] obs;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, BL_ctrl, Busy,
                Timeout, ResultSrc, ALUSrcB, ALUControl};

  function automatic logic [18:0] ov(bit pcw, bit adr, bit mw, bit irw, bit asa, bit rw,
                                     bit bl, bit busy, bit to, logic [1:0] rs,
                                     logic [1:0] asb, logic [3:0] alu);
    return {pcw, adr, mw, irw, asa, rw, bl, busy, to, rs, asb, 2'b00, alu};
  endfunction

  //                                  pcw adr mw irw asa rw bl bsy to  rs     asb    alu
  localparam logic [18:0] F_RDY   = ov(1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b10, 2'b10, 4'b0100);
  localparam logic [18:0] F_STL   = ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 2'b10, 4'b0100);
  localparam logic [18:0] DEC     = ov(0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b10, 2'b10, 4'b0100);
  localparam logic [18:0] EXR_ADD = ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0100);
  localparam logic [18:0] EXR_SUB = ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0010);
  localparam logic [18:0] EXI_ORR = ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 4'b1100);
  localparam logic [18:0] AWB_W   = ov(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 4'b0100);
  localparam logic [18:0] AWB_N   = ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0100);
  localparam logic [18:0] AWB_PC  = ov(1, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 4'b0100);
  localparam logic [18:0] MADR    = ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 4'b0100);
  localparam logic [18:0] MRD     = ov(0, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0100);
  localparam logic [18:0] MWB     = ov(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b01, 2'b00, 4'b0100);
  localparam logic [18:0] MWR     = ov(0, 1, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0100);
  localparam logic [18:0] BR_T    = ov(1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 4'b0100);
  localparam logic [18:0] BR_N    = ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 4'b0100);
  localparam logic [18:0] LNK     = ov(0, 0, 0, 0, 0, 1, 1, 1, 0, 2'b10, 2'b00, 4'b0100);
  localparam logic [18:0] ERR     = ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0100);

  // Compare the outputs of the current cycle at the negedge, then step to just
  // after the next posedge so the caller can drive the next cycle's inputs.
  task automatic cyc(input string tag, input logic [18:0] exp);
    @(negedge clk);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // {ImmSrc, RegSrc} is a combinational decode of Op.
  task automatic chk_src(input string tag, input logic [3:0] exp);
    #1;
    checks++;
    assert ({ImmSrc, RegSrc} === exp) else begin
      errors++;
      $error("FAIL %s: observed=%04b expected=%04b", tag, {ImmSrc, RegSrc}, exp);
    end
  endtask

  task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r);
    Cond = c; Op = o; Funct = f; Rd = r;
  endtask

  initial begin
    RESET_N = 1'b0; MemReady = 1'b0; ALUFlags = 4'b0000;
    instr(4'hE, 2'b00, 6'b000000, 4'd0);
    @(posedge clk); #1;
    cyc("reset_fetch", F_STL);
    RESET_N = 1'b1;

    // ADD R1: register form, 4 cycles.
    instr(4'hE, 2'b00, 6'b001000, 4'd1); MemReady = 1'b1;
    chk_src("add_src", 4'b0000);
    cyc("add_fetch", F_RDY); cyc("add_decode", DEC);
    cyc("add_execr", EXR_ADD); cyc("add_aluwb", AWB_W);

    // ORR immediate (no S flag).
    instr(4'hE, 2'b00, 6'b111000, 4'd2);
    cyc("orr_fetch", F_RDY); cyc("orr_decode", DEC);
    cyc("orr_execi", EXI_ORR); cyc("orr_aluwb", AWB_W);

    // LDR: memory stalls for 3 cycles, then is ready.
    instr(4'hE, 2'b01, 6'b011001, 4'd2);
    chk_src("ldr_src", 4'b0110);
    cyc("ldr_fetch", F_RDY); MemReady = 1'b0;
    cyc("ldr_decode", DEC); cyc("ldr_memadr", MADR);
    for (int i = 0; i < 3; i++) cyc("ldr_memread_stall", MRD);
    MemReady = 1'b1;
    cyc("ldr_memread_ready", MRD); cyc("ldr_memwb", MWB);

    // STR: MemWrite held through stalls.
    instr(4'hE, 2'b01, 6'b011000, 4'd3);
    cyc("str_fetch", F_RDY); MemReady = 1'b0;
    cyc("str_decode", DEC); cyc("str_memadr", MADR);
    cyc("str_memwrite_stall0", MWR); cyc("str_memwrite_stall1", MWR);
    MemReady = 1'b1;
    cyc("str_memwrite_ready", MWR);

    // SUBS sets Z=1. Flags become 0100.
    instr(4'hE, 2'b00, 6'b000101, 4'd3); ALUFlags = 4'b0100;
    cyc("subs_fetch", F_RDY); cyc("subs_decode", DEC);
    cyc("subs_execr", EXR_SUB); cyc("subs_aluwb", AWB_W);

    // ADDNE with Z=1: the condition fails, so there is no register write.
    instr(4'h1, 2'b00, 6'b001000, 4'd4);
    cyc("addne_fetch", F_RDY); cyc("addne_decode", DEC);
    cyc("addne_execr", EXR_ADD); cyc("addne_aluwb", AWB_N);

    // BNE is not taken; BEQ is taken.
    instr(4'h1, 2'b10, 6'b000000, 4'd0);
    chk_src("b_src", 4'b1001);
    cyc("bne_fetch", F_RDY); cyc("bne_decode", DEC); cyc("bne_branch", BR_N);
    instr(4'h0, 2'b10, 6'b000000, 4'd0);
    cyc("beq_fetch", F_RDY); cyc("beq_decode", DEC); cyc("beq_branch", BR_T);

    // CMPGT with Z=1: the condition fails and the flags are unchanged.
    instr(4'hC, 2'b00, 6'b010101, 4'd0); ALUFlags = 4'b1001;
    cyc("cmpgt0_fetch", F_RDY); cyc("cmpgt0_decode", DEC);
    cyc("cmpgt0_execr", EXR_SUB); cyc("cmpgt0_aluwb", AWB_N);
    instr(4'h0, 2'b10, 6'b000000, 4'd0);
    cyc("beq2_fetch", F_RDY); cyc("beq2_decode", DEC); cyc("beq2_branch_kept_z", BR_T);

    // SUBS sets flags N=1, V=1, Z=0. CMPGT then passes and writes flags 0010.
    instr(4'hE, 2'b00, 6'b000101, 4'd3); ALUFlags = 4'b1001;
    cyc("subs2_fetch", F_RDY); cyc("subs2_decode", DEC);
    cyc("subs2_execr", EXR_SUB); cyc("subs2_aluwb", AWB_W);
    instr(4'hC, 2'b00, 6'b010101, 4'd0); ALUFlags = 4'b0010;
    cyc("cmpgt1_fetch", F_RDY); cyc("cmpgt1_decode", DEC);
    cyc("cmpgt1_execr", EXR_SUB); cyc("cmpgt1_aluwb_noreg", AWB_N);
    instr(4'h0, 2'b10, 6'b000000, 4'd0);
    cyc("beq3_fetch", F_RDY); cyc("beq3_decode", DEC); cyc("beq3_branch", BR_N);
    instr(4'h2, 2'b10, 6'b000000, 4'd0);
    cyc("bcs_fetch", F_RDY); cyc("bcs_decode", DEC); cyc("bcs_branch", BR_T);

    // ADD to R15 drives PCWrite in ALUWB.
    instr(4'hE, 2'b00, 6'b001000, 4'hF);
    cyc("addpc_fetch", F_RDY); cyc("addpc_decode", DEC);
    cyc("addpc_execr", EXR_ADD); cyc("addpc_aluwb", AWB_PC);

    // BL: goes through LINK only when the option is built in.
    instr(4'hE, 2'b10, 6'b010000, 4'd0);
    cyc("bl_fetch", F_RDY); cyc("bl_decode", DEC); cyc("bl_branch", BR_T);
`ifdef MC_CTRL_BL_EN
    cyc("bl_link", LNK);
`endif
    cyc("bl_back_to_fetch", F_RDY);

    // Op=11 returns straight to FETCH. The next FETCH then tests the stall
    // bound: MemReady arrives on the last tolerated cycle and wins.
    instr(4'hE, 2'b11, 6'b000000, 4'd0);
    cyc("op11_decode", DEC);
    MemReady = 1'b0;
    for (int i = 0; i < 15; i++) cyc("fetch_stall_edge", F_STL);
    MemReady = 1'b1;
    cyc("fetch_ready_at_limit", F_RDY);
    cyc("limit_decode", DEC);

    // 16 stall cycles, then ERROR. ERROR is sticky even once MemReady returns.
    MemReady = 1'b0;
    for (int i = 0; i < 16; i++) cyc("fetch_stall_timeout", F_STL);
    cyc("error_entered", ERR);
    MemReady = 1'b1;
    cyc("error_sticky0", ERR); cyc("error_sticky1", ERR);

    // One reset cycle recovers to FETCH and clears the flags. The C flag was
    // 1, so BCS is no longer taken.
    RESET_N = 1'b0; MemReady = 1'b0;
    cyc("error_before_reset", ERR);
    RESET_N = 1'b1;
    cyc("after_reset_fetch", F_STL);
    instr(4'h2, 2'b10, 6'b000000, 4'd0); MemReady = 1'b1;
    cyc("post_reset_fetch", F_RDY); cyc("post_reset_decode", DEC);
    cyc("post_reset_bcs", BR_N);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
